pt_uart_loader: RTL and testbench

- Upstream feeder for the PT2262 tri-state encoder (`pt_enc`).
- Receives 8N1 UART bytes on `rx` and assembles three bytes MSB-first into a 24-bit codeword (12 two-bit codebits).
- Validates the word, then loads it into the encoder through the encoder's `ld`/`ad` interface.
- Each accepted word is loaded REPEAT times back-to-back, each time waiting for the encoder's `done`.

---
 rtl/pt_uart_loader_if.sv | 19 +
 rtl/pt_uart_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pt_uart_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pt_uart_loader_if.sv
// Encoder load interface: the loader drives the strobe and codeword,
// the PT2262 encoder answers with its idle/done flag.
interface pt_uart_loader_if;
   logic        ld;        // one-cycle load strobe
   logic [23:0] ad;        // 12 two-bit codebits, MSB pair first
   logic        enc_done;  // high while the encoder is idle

   modport master (
      output ld,
      output ad,
      input  enc_done
   );

   modport slave (
      input  ld,
      input  ad,
      output enc_done
   );
endinterface

// File: rtl/pt_uart_loader.sv
// UART front end for the PT2262 encoder: receives three 8N1 bytes,
// builds a 24-bit tri-state codeword, rejects illegal codebits, and
// loads the accepted word into the encoder REPEAT times.
module pt_uart_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_CLKS = 4096,
   parameter int REPEAT       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   pt_uart_loader_if.master  enc,
   output logic              busy,
   output logic              frame_err,
   output logic              ovr
);

   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
   localparam int RW    = $clog2(REPEAT + 1);

   localparam logic [TW-1:0]    HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]    FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [RW-1:0]    REP_MAX = RW'(REPEAT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {L_IDLE, L_WAIT, L_LOAD, L_HOLD}     ld_state_t;

   // synchronizer
   logic rx_meta_q, rx_sync_q;

   // receiver
   rx_state_t       rx_state_q, rx_state_d;
   logic            armed_q, armed_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            byte_valid, stop_err;

   // assembler
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [15:0]      word_hi_q, word_hi_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [23:0]      ad_q, ad_d;
   logic             busy_q, busy_d;
   logic             frame_err_q, frame_err_d;
   logic             ovr_q, ovr_d;
   logic [23:0]      word;
   logic             illegal;

   // loader
   ld_state_t       l_state_q, l_state_d;
   logic [RW-1:0]   rep_q, rep_d;
   logic            hold_q, hold_d;
   logic            ld;
   logic            busy_clr;

   // Two-flop synchronizer for the asynchronous line; preloads idle-high.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // All state registers of receiver, assembler and loader.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q  <= RX_IDLE;
         armed_q     <= 1'b0;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         byte_cnt_q  <= '0;
         word_hi_q   <= '0;
         tmo_q       <= '0;
         ad_q        <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         ovr_q       <= 1'b0;
         l_state_q   <= L_IDLE;
         rep_q       <= '0;
         hold_q      <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         armed_q     <= armed_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         byte_cnt_q  <= byte_cnt_d;
         word_hi_q   <= word_hi_d;
         tmo_q       <= tmo_d;
         ad_q        <= ad_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         ovr_q       <= ovr_d;
         l_state_q   <= l_state_d;
         rep_q       <= rep_d;
         hold_q      <= hold_d;
      end
   end

   // Receiver: arm on idle line, mid-bit sampling, LSB-first, stop check.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      rx_state_d = rx_state_q;
      armed_d    = armed_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!armed_q) begin
               if (rx_sync_q) armed_d = 1'b1;
            end else if (!rx_sync_q) begin
               rx_state_d = RX_START;
               timer_d    = '0;
            end
         end
         RX_START: begin
            if (timer_q == HALF_M1) begin
               timer_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;      // glitch, silently ignored
               end else begin
                  rx_state_d = RX_DATA;
                  bit_idx_d  = '0;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RX_DATA: begin
            if (timer_q == FULL_M1) begin
               timer_d = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                   bit_idx_d  = bit_idx_q + 3'd1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RX_STOP: begin
            if (timer_q == FULL_M1) begin
               timer_d    = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  byte_valid = 1'b1;
               end else begin
                  stop_err = 1'b1;
                  armed_d  = 1'b0;           // wait for the line to go idle again
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Assembler: byte stacking, inter-byte timeout, codebit check, word hand-off.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      word_hi_d   = word_hi_q;
      tmo_d       = tmo_q;
      ad_d        = ad_q;
      busy_d      = busy_q;
      frame_err_d = 1'b0;
      ovr_d       = 1'b0;
      word        = {word_hi_q, shift_q};
      illegal     = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (word[2*k +: 2] == 2'b11) illegal = 1'b1;
      end
      if (byte_valid) begin
         // A byte arriving in the timeout cycle takes precedence.
         tmo_d = '0;
         case (byte_cnt_q)
            2'd0: begin
               word_hi_d[15:8] = shift_q;
               byte_cnt_d      = 2'd1;
            end
            2'd1: begin
               word_hi_d[7:0] = shift_q;
               byte_cnt_d     = 2'd2;
            end
            default: begin
               byte_cnt_d = 2'd0;
               if (illegal)     frame_err_d = 1'b1;
               else if (busy_q) ovr_d       = 1'b1;  // includes the cycle busy falls
               else begin
                  ad_d   = word;
                  busy_d = 1'b1;
               end
            end
         endcase
      end else if (stop_err) begin
         frame_err_d = 1'b1;
         byte_cnt_d  = 2'd0;
         tmo_d       = '0;
      end else if (byte_cnt_q != 2'd0) begin
         if (tmo_q == TMO_M1) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = 2'd0;
            tmo_d       = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end
      if (busy_clr) busy_d = 1'b0;
   end

   // Loader: wait for encoder idle, strobe, hold off, repeat.
   always_comb begin
      l_state_d = l_state_q;
      rep_d     = rep_q;
      hold_d    = hold_q;
      ld        = 1'b0;
      busy_clr  = 1'b0;
      case (l_state_q)
         L_IDLE: begin
            rep_d = '0;
            if (busy_q) l_state_d = L_WAIT;
         end
         L_WAIT: begin
            if (enc.enc_done) l_state_d = L_LOAD;
         end
         L_LOAD: begin
            ld        = 1'b1;
            rep_d     = rep_q + RW'(1);
            hold_d    = 1'b0;
            l_state_d = L_HOLD;
         end
         L_HOLD: begin
            // enc_done is ignored here so the encoder has time to drop it.
            if (!hold_q) begin
               hold_d = 1'b1;
            end else if (rep_q < REP_MAX) begin
               l_state_d = L_WAIT;
            end else begin
               busy_clr  = 1'b1;
               l_state_d = L_IDLE;
            end
         end
         default: l_state_d = L_IDLE;
      endcase
   end

   assign enc.ld    = ld;
   assign enc.ad    = ad_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign ovr       = ovr_q;

endmodule

// File: tb/tb_pt_uart_loader.sv
// Bench for pt_uart_loader: UART byte driver, simple encoder model,
// scoreboard of expected encoder loads, per-scenario checks.
module tb_pt_uart_loader;

   localparam int CPB = 16;
   localparam int TMO = 1024;
   localparam int REP = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;
   logic busy, frame_err, ovr;

   pt_uart_loader_if ifc ();

   pt_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_CLKS(TMO),
      .REPEAT      (REP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .enc      (ifc.master),
      .busy     (busy),
      .frame_err(frame_err),
      .ovr      (ovr)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // scoreboard and monitor state
   logic [23:0] exp_q[$];
   logic [23:0] exp_want;
   int cyc = 0, ld_cnt = 0, fe_cnt = 0, ovr_cnt = 0, stab_err = 0, both_err = 0;
   int ld_cyc_last = 0, ld_cyc_prev = 0, first_ld_cyc = 0, busy_rise_cyc = 0;
   bit first_pending = 0, busy_prev = 0, ld_prev = 0;
   logic [23:0] ad_prev = '0;

   // encoder model
   bit model_en = 0;
   int drop = 0;

   // Encoder model: done stays high unless enabled, then drops 500 cycles per load.
   always @(negedge clk) begin
      if (!model_en) begin
         ifc.enc_done = 1'b1;
         drop = 0;
      end else if (ifc.ld === 1'b1) begin
         ifc.enc_done = 1'b0;
         drop = 500;
      end else if (drop > 0) begin
         drop--;
         if (drop == 0) ifc.enc_done = 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each load and tallies pulses.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (ifc.ld === 1'b1) begin
            ld_cnt++;
            ld_cyc_prev = ld_cyc_last;
            ld_cyc_last = cyc;
            if (first_pending) begin
               first_ld_cyc  = cyc;
               first_pending = 0;
            end
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_ld: got ad=%h, expected no load", ifc.ad);
            end else begin
               exp_want = exp_q.pop_front();
               if (ifc.ad !== exp_want) $display("FAIL ld_ad: got %h, expected %h", ifc.ad, exp_want);
               else n_pass++;
            end
            n_total++;
            if (ld_prev) $display("FAIL ld_width: ld high two cycles running, expected 1-cycle pulse");
            else n_pass++;
         end
         if (frame_err === 1'b1) fe_cnt++;
         if (ovr === 1'b1) ovr_cnt++;
         if (frame_err === 1'b1 && ovr === 1'b1) both_err++;
         if (busy === 1'b1 && busy_prev && ifc.ad !== ad_prev) stab_err++;
         if (busy === 1'b1 && !busy_prev) begin
            busy_rise_cyc = cyc;
            first_pending = 1;
         end
      end
      busy_prev = (busy === 1'b1);
      ld_prev   = (ifc.ld === 1'b1);
      ad_prev   = ifc.ad;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // 8N1 byte; a bad stop bit leaves the line low for the caller to release.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = bad_stop ? 1'b0 : 1'b1;
      tick(CPB);
   endtask

   task automatic send_word(input logic [7:0] b0, b1, b2, input bit expect_load);
      if (expect_load) begin
         for (int i = 0; i < REP; i++) exp_q.push_back({b0, b1, b2});
      end
      send_byte(b0, 0);
      send_byte(b1, 0);
      send_byte(b2, 0);
   endtask

   task automatic wait_not_busy(input int budget, input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick(1);
         n++;
      end
      if (busy !== 1'b0) begin
         n_total++;
         $display("FAIL %s_idle_timeout: busy still %b after %0d cycles, expected 0", tag, busy, budget);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(3);
      n_total++; if (ifc.ld !== 1'b0) $display("FAIL rst_ld: got %b, expected 0", ifc.ld); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else n_pass++;
      n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b, expected 0", frame_err); else n_pass++;
      n_total++; if (ovr !== 1'b0) $display("FAIL rst_ovr: got %b, expected 0", ovr); else n_pass++;
      n_total++; if (ifc.ad !== 24'h000000) $display("FAIL rst_ad: got %h, expected 000000", ifc.ad); else n_pass++;
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic test_basic;
      int ld0 = ld_cnt, fe0 = fe_cnt;
      send_word(8'h55, 8'hAA, 8'h00, 1);
      wait_not_busy(200, "basic");
      tick(2);
      n_total++; if (ld_cnt - ld0 != 2) $display("FAIL basic_ld_count: got %0d, expected 2", ld_cnt - ld0); else n_pass++;
      n_total++; if (ifc.ad !== 24'h55AA00) $display("FAIL basic_ad: got %h, expected 55aa00", ifc.ad); else n_pass++;
      n_total++; if (first_ld_cyc - busy_rise_cyc != 2) $display("FAIL basic_latency: got %0d, expected 2", first_ld_cyc - busy_rise_cyc); else n_pass++;
      n_total++; if (ld_cyc_last - ld_cyc_prev < 3) $display("FAIL basic_spacing: got %0d, expected >=3", ld_cyc_last - ld_cyc_prev); else n_pass++;
      n_total++; if (fe_cnt != fe0) $display("FAIL basic_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL basic_pending: got %0d loads outstanding, expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_enc_handshake;
      int ld0 = ld_cnt;
      model_en = 1;
      send_word(8'h12, 8'h21, 8'h09, 1);
      wait_not_busy(3000, "handshake");
      model_en = 0;
      tick(2);
      n_total++; if (ld_cnt - ld0 != 2) $display("FAIL hs_ld_count: got %0d, expected 2", ld_cnt - ld0); else n_pass++;
      n_total++; if (ld_cyc_last - ld_cyc_prev < 500) $display("FAIL hs_gap: got %0d cycles, expected >=500", ld_cyc_last - ld_cyc_prev); else n_pass++;
      n_total++; if (ifc.ad !== 24'h122109) $display("FAIL hs_ad: got %h, expected 122109", ifc.ad); else n_pass++;
   endtask

   task automatic test_illegal;
      int ld0 = ld_cnt, fe0 = fe_cnt;
      send_word(8'hC0, 8'h00, 8'h00, 0);
      tick(20);
      n_total++; if (fe_cnt - fe0 != 1) $display("FAIL illegal_frame_err: got %0d pulses, expected 1", fe_cnt - fe0); else n_pass++;
      n_total++; if (ld_cnt != ld0) $display("FAIL illegal_ld: got %0d loads, expected 0", ld_cnt - ld0); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL illegal_busy: got %b, expected 0", busy); else n_pass++;
   endtask

   task automatic test_timeout;
      int ld0 = ld_cnt, fe0 = fe_cnt;
      send_byte(8'h55, 0);
      tick(TMO + 10);
      n_total++; if (fe_cnt - fe0 != 1) $display("FAIL tmo_frame_err: got %0d pulses, expected 1", fe_cnt - fe0); else n_pass++;
      // 0x03 ends in codebit pair 11, so this word must be rejected.
      send_word(8'h01, 8'h02, 8'h03, 0);
      tick(20);
      n_total++; if (fe_cnt - fe0 != 2) $display("FAIL tmo_illegal: got %0d pulses, expected 2", fe_cnt - fe0); else n_pass++;
      send_word(8'h01, 8'h02, 8'h04, 1);
      wait_not_busy(200, "timeout");
      tick(2);
      n_total++; if (ifc.ad !== 24'h010204) $display("FAIL tmo_ad: got %h, expected 010204", ifc.ad); else n_pass++;
      n_total++; if (ld_cnt - ld0 != 2) $display("FAIL tmo_ld_count: got %0d, expected 2", ld_cnt - ld0); else n_pass++;
   endtask

   task automatic test_stop_err;
      int ld0 = ld_cnt, fe0 = fe_cnt;
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      tick(2 * CPB);
      rx = 1'b1;
      tick(3 * CPB);
      n_total++; if (fe_cnt - fe0 != 1) $display("FAIL stop_frame_err: got %0d pulses, expected 1", fe_cnt - fe0); else n_pass++;
      n_total++; if (ld_cnt != ld0) $display("FAIL stop_no_ld: got %0d loads, expected 0", ld_cnt - ld0); else n_pass++;
      send_word(8'h11, 8'h22, 8'h44, 1);
      wait_not_busy(200, "stop");
      tick(2);
      n_total++; if (ifc.ad !== 24'h112244) $display("FAIL stop_ad: got %h, expected 112244", ifc.ad); else n_pass++;
      n_total++; if (ld_cnt - ld0 != 2) $display("FAIL stop_ld_count: got %0d, expected 2", ld_cnt - ld0); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int ld0 = ld_cnt, fe0 = fe_cnt, ov0 = ovr_cnt, n = 0;
      model_en = 1;
      send_word(8'h55, 8'hAA, 8'h00, 1);
      send_word(8'h00, 8'h00, 8'h01, 0);
      tick(1);
      n_total++; if (ovr_cnt - ov0 != 1) $display("FAIL b2b_ovr: got %0d pulses, expected 1", ovr_cnt - ov0); else n_pass++;
      n_total++; if (ifc.ad !== 24'h55AA00) $display("FAIL b2b_ad_kept: got %h, expected 55aa00", ifc.ad); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b, expected 1", busy); else n_pass++;
      while (ld_cnt - ld0 < 2 && n < 2000) begin
         tick(1);
         n++;
      end
      n_total++; if (ld_cnt - ld0 != 2) $display("FAIL b2b_second_ld: got %0d loads, expected 2", ld_cnt - ld0); else n_pass++;
      // abort the second repeat while it is still in progress
      rst_n = 1'b0;
      tick(1);
      n_total++; if (ifc.ld !== 1'b0) $display("FAIL b2b_rst_ld: got %b, expected 0", ifc.ld); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_rst_busy: got %b, expected 0", busy); else n_pass++;
      n_total++; if (ifc.ad !== 24'h000000) $display("FAIL b2b_rst_ad: got %h, expected 000000", ifc.ad); else n_pass++;
      n_total++; if (fe_cnt != fe0) $display("FAIL b2b_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); else n_pass++;
      model_en = 0;
      rst_n = 1'b1;
      tick(4);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_enc_handshake();
      test_illegal();
      test_timeout();
      test_stop_err();
      test_back_to_back();
      n_total++; if (stab_err != 0) $display("FAIL ad_stable: got %0d changes while busy, expected 0", stab_err); else n_pass++;
      n_total++; if (both_err != 0) $display("FAIL err_ovr_overlap: got %0d overlapping cycles, expected 0", both_err); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d loads outstanding, expected 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
